// File: rtl/periodic_serial_tx.sv
// Purpose : frames and serialises an MSG_W-bit message on a one-wire channel,
//           then holds a programmable stand-by gap of SB+1 cycles.
//           Runs continuously while enabled, or one frame per start pulse.
// Latency : first bit appears one cycle after the triggering edge; in continuous
//           mode the period is FRAME_W + SB + 1 cycles, with no idle cycle between frames.
// Flow    : no backpressure. EN only gates new frame starts. A frame and its gap
//           always run to completion once started; only RST can abort them.
//
// Optional feature macro: PARITY_EN. When it is defined, an even-parity bit
// (XOR of the latched message bits) is appended after the data bits.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   EN         in   enable for new frame starts
//   oneshot    in   0 = continuous, 1 = one frame per start pulse
//   start      in   one-shot trigger, sampled only in IDLE
//   msg        in   message, latched at frame start
//   SB         in   stand-by count, latched at frame start; gap = SB+1 cycles
//   state_send out  high while frame bits are on state_out
//   state_out  out  serial data, 0 whenever state_send is low
//   busy       out  high in SEND or GAP
//   frame_done out  one-cycle pulse on the first GAP cycle
module periodic_serial_tx #(
  parameter int MSG_W     = 4,
  parameter int SB_W      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             oneshot,
  input  logic             start,
  input  logic [MSG_W-1:0] msg,
  input  logic [SB_W-1:0]  SB,
  output logic             state_send,
  output logic             state_out,
  output logic             busy,
  output logic             frame_done
);

`ifdef PARITY_EN
  localparam int FRAME_W = MSG_W + 1;
`else
  localparam int FRAME_W = MSG_W;
`endif
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q;
  logic [FRAME_W-1:0] shreg_q;      // remaining frame bits, next bit at the MSB
  logic [SB_W-1:0]    sb_q;
  logic [SB_W-1:0]    gap_cnt_q;
  logic [CNT_W-1:0]   bit_cnt_q;    // index of the bit currently on state_out
  logic               state_send_q;
  logic               state_out_q;
  logic               busy_q;
  logic               frame_done_q;

  logic [MSG_W-1:0]   msg_ord_d;
  logic [FRAME_W-1:0] frame_d;
  logic               load_d;

  // Reorder the live message so the first bit to transmit sits at the MSB;
  // the shift register then always shifts left regardless of bit order.
  always_comb begin
    msg_ord_d = msg;
    if (!MSB_FIRST) begin
      for (int i = 0; i < MSG_W; i++) begin
        msg_ord_d[i] = msg[MSG_W-1-i];
      end
    end
`ifdef PARITY_EN
    frame_d = {msg_ord_d, ^msg};
`else
    frame_d = msg_ord_d;
`endif
  end

  // A new frame starts either from IDLE on a trigger, or straight out of the
  // last gap cycle when continuous mode is still requested.
  always_comb begin
    load_d = 1'b0;
    if (state_q == IDLE) begin
      load_d = EN && (!oneshot || start);
    end else if (state_q == GAP && gap_cnt_q == sb_q) begin
      load_d = EN && !oneshot;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sb_q         <= '0;
      gap_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      state_send_q <= 1'b0;
      state_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (load_d) begin
        state_q      <= SEND;
        sb_q         <= SB;
        bit_cnt_q    <= '0;
        state_out_q  <= frame_d[FRAME_W-1];
        shreg_q      <= frame_d << 1;
        state_send_q <= 1'b1;
        busy_q       <= 1'b1;
      end else begin
        case (state_q)
          SEND: begin
            if (bit_cnt_q == LAST_BIT) begin
              state_q      <= GAP;
              gap_cnt_q    <= '0;
              state_send_q <= 1'b0;
              state_out_q  <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
              state_out_q <= shreg_q[FRAME_W-1];
              shreg_q     <= shreg_q << 1;
            end
          end
          GAP: begin
            // Counter stops at sb_q, so SB at its maximum never wraps.
            if (gap_cnt_q == sb_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q + SB_W'(1);
            end
          end
          IDLE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q      <= IDLE;
            state_send_q <= 1'b0;
            state_out_q  <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_send = state_send_q;
  assign state_out  = state_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
